// File: rtl/tmds_encoder_mc.sv
// Multi-lane TMDS encoder with fixed 12-cycle latency, DE lookahead and optional
// HDMI preamble/guard-band insertion. Define TMDS_DISP_MON_EN to expose disp_mon.
module tmds_encoder_mc #(
  parameter int NUM_CH    = 3,
  parameter int HDMI_MODE = 0
) (
  input  logic                  clkin,
  input  logic                  rstin,
  input  logic [8*NUM_CH-1:0]   din,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  de,
  output logic [10*NUM_CH-1:0]  dout,
  output logic [1:0]            period_o
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [5*NUM_CH-1:0]   disp_mon
`endif
);

  typedef enum logic [1:0] {
    PER_CTRL     = 2'd0,
    PER_PREAMBLE = 2'd1,
    PER_GUARD    = 2'd2,
    PER_VIDEO    = 2'd3
  } period_t;

  localparam int TAPS = 11;
  localparam int CUR  = TAPS - 1;
  localparam bit HDMI_EN = HDMI_MODE[0];

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'h354;
      2'b01:   t = 10'h0AB;
      2'b10:   t = 10'h154;
      2'b11:   t = 10'h2AB;
      default: t = 10'h354;
    endcase
    return t;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    return {3'b000, v[0]} + {3'b000, v[1]} + {3'b000, v[2]} + {3'b000, v[3]} +
           {3'b000, v[4]} + {3'b000, v[5]} + {3'b000, v[6]} + {3'b000, v[7]};
  endfunction

  function automatic logic [8:0] stage1_qm(input logic [7:0] d);
    logic [8:0] q;
    logic       use_xnor;
    logic [3:0] n1;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [8*NUM_CH-1:0] tap_din_r [TAPS];
  logic [TAPS-1:0]     tap_de_r;
  logic [TAPS-1:0]     tap_hs_r;
  logic [TAPS-1:0]     tap_vs_r;
  logic [TAPS-1:0]     tap_fresh_r;
  period_t             cls_s;
  period_t             cls_r;
  period_t             state_r;
  period_t             state_n;

  // Input delay line; tap_fresh_r marks cycles that really came from the inputs,
  // so reset-cleared taps never trigger a preamble/guard lookahead.
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      for (int i = 0; i < TAPS; i++) begin
        tap_din_r[i] <= '0;
      end
      tap_de_r    <= '0;
      tap_hs_r    <= '0;
      tap_vs_r    <= '0;
      tap_fresh_r <= '0;
    end else begin
      tap_din_r[0] <= din;
      for (int i = 1; i < TAPS; i++) begin
        tap_din_r[i] <= tap_din_r[i-1];
      end
      tap_de_r    <= {tap_de_r[TAPS-2:0], de};
      tap_hs_r    <= {tap_hs_r[TAPS-2:0], hsync};
      tap_vs_r    <= {tap_vs_r[TAPS-2:0], vsync};
      tap_fresh_r <= {tap_fresh_r[TAPS-2:0], 1'b1};
    end
  end

  // Period of the oldest tap, using de of the ten younger taps as lookahead.
  always_comb begin
    cls_s = PER_CTRL;
    if (tap_de_r[CUR]) begin
      cls_s = PER_VIDEO;
    end else if (HDMI_EN && tap_fresh_r[CUR] && (tap_de_r[CUR-1] || tap_de_r[CUR-2])) begin
      cls_s = PER_GUARD;
    end else if (HDMI_EN && tap_fresh_r[CUR] && (|tap_de_r[CUR-3:0])) begin
      cls_s = PER_PREAMBLE;
    end else begin
      cls_s = PER_CTRL;
    end
  end

  // Period state: stage-1 class register and output-aligned state register.
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      cls_r   <= PER_CTRL;
      state_r <= PER_CTRL;
    end else begin
      cls_r   <= cls_s;
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    case (cls_r)
      PER_CTRL, PER_PREAMBLE, PER_GUARD, PER_VIDEO: state_n = cls_r;
      default:                                      state_n = PER_CTRL;
    endcase
  end

  assign period_o = state_r;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    localparam int          LANE      = ch;
    localparam bit          IS_LANE0  = (LANE == 32'sd0);
    localparam logic [9:0]  GUARD_SYM = LANE[0] ? 10'h133 : 10'h2CC;

    logic [9:0]        ctl_c;
    logic [9:0]        ctl_r;
    logic [8:0]        qm_r;
    logic [9:0]        sym_c;
    logic [9:0]        sym_r;
    logic signed [4:0] cnt_c;
    logic signed [4:0] cnt_r;
    logic signed [4:0] n1s;
    logic signed [4:0] n0s;
    logic signed [4:0] diff;
    logic              q8;

    // Non-video symbol for this lane; only lane 0 carries hsync/vsync.
    always_comb begin
      ctl_c = ctl_token(2'b00);
      if (cls_s == PER_GUARD) begin
        ctl_c = GUARD_SYM;
      end else if (IS_LANE0) begin
        ctl_c = ctl_token({tap_vs_r[CUR], tap_hs_r[CUR]});
      end else if (cls_s == PER_PREAMBLE) begin
        ctl_c = ctl_token(2'b01);
      end else begin
        ctl_c = ctl_token(2'b00);
      end
    end

    // Stage 1: transition-minimised word and control symbol.
    always_ff @(posedge clkin or posedge rstin) begin
      if (rstin) begin
        qm_r  <= '0;
        ctl_r <= 10'h354;
      end else begin
        qm_r  <= stage1_qm(tap_din_r[CUR][8*ch +: 8]);
        ctl_r <= ctl_c;
      end
    end

    assign q8   = qm_r[8];
    assign n1s  = {1'b0, ones8(qm_r[7:0])};
    assign n0s  = 5'sd8 - n1s;
    assign diff = n1s - n0s;

    // Stage 2: DC balancing against the running disparity.
    always_comb begin
      sym_c = ctl_r;
      cnt_c = 5'sd0;
      if (cls_r == PER_VIDEO) begin
        if ((cnt_r == 5'sd0) || (n1s == n0s)) begin
          sym_c = {~q8, q8, q8 ? qm_r[7:0] : ~qm_r[7:0]};
          cnt_c = q8 ? (cnt_r + diff) : (cnt_r - diff);
        end else if (((cnt_r > 5'sd0) && (n1s > n0s)) || ((cnt_r < 5'sd0) && (n0s > n1s))) begin
          sym_c = {1'b1, q8, ~qm_r[7:0]};
          cnt_c = cnt_r + (q8 ? 5'sd2 : 5'sd0) - diff;
        end else begin
          sym_c = {1'b0, q8, qm_r[7:0]};
          cnt_c = cnt_r - (q8 ? 5'sd0 : 5'sd2) + diff;
        end
      end else begin
        sym_c = ctl_r;
        cnt_c = 5'sd0;
      end
    end

    always_ff @(posedge clkin or posedge rstin) begin
      if (rstin) begin
        sym_r <= '0;
        cnt_r <= 5'sd0;
      end else begin
        sym_r <= sym_c;
        cnt_r <= cnt_c;
      end
    end

    assign dout[10*ch +: 10] = sym_r;
`ifdef TMDS_DISP_MON_EN
    assign disp_mon[5*ch +: 5] = cnt_r;
`endif
  end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Scoreboard bench for tmds_encoder_mc: DVI 3-lane, HDMI 3-lane and HDMI 4-lane
// instances share one directed stimulus stream; a monitor checks due expectations.
module tb_tmds_encoder_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        hs, vs, de;
  logic [29:0] dout_dvi, dout_hdmi;
  logic [39:0] dout_h4;
  logic [1:0]  per_dvi, per_hdmi, per_h4;
`ifdef TMDS_DISP_MON_EN
  logic [14:0] dm_dvi, dm_hdmi;
  logic [19:0] dm_h4;
`endif

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int due      = 0;

  typedef struct {
    int         due;
    int         dut;
    int         lane;
    logic [9:0] val;
    string      nm;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tmds_encoder_mc #(.NUM_CH(3), .HDMI_MODE(0)) u_dvi (
    .clkin(clk), .rstin(rst), .din(din[23:0]), .hsync(hs), .vsync(vs), .de(de),
    .dout(dout_dvi), .period_o(per_dvi)
`ifdef TMDS_DISP_MON_EN
    , .disp_mon(dm_dvi)
`endif
  );

  tmds_encoder_mc #(.NUM_CH(3), .HDMI_MODE(1)) u_hdmi (
    .clkin(clk), .rstin(rst), .din(din[23:0]), .hsync(hs), .vsync(vs), .de(de),
    .dout(dout_hdmi), .period_o(per_hdmi)
`ifdef TMDS_DISP_MON_EN
    , .disp_mon(dm_hdmi)
`endif
  );

  tmds_encoder_mc #(.NUM_CH(4), .HDMI_MODE(1)) u_h4 (
    .clkin(clk), .rstin(rst), .din(din), .hsync(hs), .vsync(vs), .de(de),
    .dout(dout_h4), .period_o(per_h4)
`ifdef TMDS_DISP_MON_EN
    , .disp_mon(dm_h4)
`endif
  );

  function automatic logic [9:0] observe(input int dut, input int lane);
    logic [39:0] d;
    logic [1:0]  p;
    case (dut)
      0:       begin d = {10'h000, dout_dvi};  p = per_dvi;  end
      1:       begin d = {10'h000, dout_hdmi}; p = per_hdmi; end
      default: begin d = dout_h4;              p = per_h4;   end
    endcase
    if (lane == -1) return {8'h00, p};
`ifdef TMDS_DISP_MON_EN
    if (lane == -2) return {5'b00000, dm_dvi[4:0]};
`endif
    return d[10*lane +: 10];
  endfunction

  function automatic bit legal(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return 1'b1;
    case (a)
      2'd1:    return (b == 2'd2);
      2'd2:    return (b == 2'd3);
      default: return 1'b1;
    endcase
  endfunction

  task automatic push(input int dut, input int lane, input int when, input logic [9:0] val, input string nm);
    exp_t e;
    e.due = when; e.dut = dut; e.lane = lane; e.val = val; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic expect_all(input int dut, input logic [9:0] l0, input logic [9:0] l1,
                            input logic [9:0] l2, input logic [9:0] l3, input logic [1:0] p,
                            input string nm);
    push(dut, 0, due, l0, nm);
    push(dut, 1, due, l1, nm);
    push(dut, 2, due, l2, nm);
    if (dut == 2) push(dut, 3, due, l3, nm);
    push(dut, -1, due, {8'h00, p}, {nm, "_period"});
  endtask

  task automatic hdmi_both(input logic [9:0] l0, input logic [9:0] l1, input logic [9:0] l2,
                           input logic [9:0] l3, input logic [1:0] p, input string nm);
    expect_all(1, l0, l1, l2, l3, p, nm);
    expect_all(2, l0, l1, l2, l3, p, nm);
  endtask

  task automatic expect_same(input logic [9:0] l0, input logic [9:0] l1, input logic [9:0] l2,
                             input logic [9:0] l3, input logic [1:0] p, input string nm);
    expect_all(0, l0, l1, l2, l3, p, nm);
    hdmi_both(l0, l1, l2, l3, p, nm);
  endtask

  // Drive one input cycle; the edge that samples it is cyc+1, its output is due 12 later.
  task automatic drive(input logic [31:0] d, input logic h, input logic v, input logic e);
    din = d; hs = h; vs = v; de = e;
    due = cyc + 13;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops due expectations and checks period legality every cycle.
  initial begin
    logic [1:0] prev_h;
    logic [1:0] prev_h4;
    logic [9:0] got;
    prev_h  = 2'd0;
    prev_h4 = 2'd0;
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          got = observe(sb[i].dut, sb[i].lane);
          n_checks++;
          if (got !== sb[i].val) begin
            n_fail++;
            $display("FAIL %s: dut %0d lane %0d cycle %0d got %h required %h",
                     sb[i].nm, sb[i].dut, sb[i].lane, cyc, got, sb[i].val);
          end
          sb.delete(i);
        end
      end
      if (rst) begin
        prev_h  = 2'd0;
        prev_h4 = 2'd0;
      end else begin
        n_checks += 3;
        if (!legal(prev_h, per_hdmi)) begin
          n_fail++;
          $display("FAIL period_transition hdmi3: cycle %0d got %0d -> %0d", cyc, prev_h, per_hdmi);
        end
        if (!legal(prev_h4, per_h4)) begin
          n_fail++;
          $display("FAIL period_transition hdmi4: cycle %0d got %0d -> %0d", cyc, prev_h4, per_h4);
        end
        if ((per_dvi == 2'd1) || (per_dvi == 2'd2)) begin
          n_fail++;
          $display("FAIL dvi_period_class: cycle %0d got %0d required 0 or 3", cyc, per_dvi);
        end
        prev_h  = per_hdmi;
        prev_h4 = per_h4;
      end
    end
  end

  initial begin
    logic [9:0] s0, s1;
    rst = 1'b1; din = 32'h0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    due = cyc;
    for (int k = 0; k < 3; k++) expect_all(k, 10'h000, 10'h000, 10'h000, 10'h000, 2'd0, "reset_state");
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      due = cyc + k;
      expect_same(10'h354, 10'h354, 10'h354, 10'h354, 2'd0, "post_reset_ctrl");
    end

    // Long blank with hsync=1, de rising at input cycle 20.
    for (int k = 0; k < 20; k++) begin
      drive(32'h0, 1'b1, 1'b0, 1'b0);
      expect_all(0, 10'h0AB, 10'h354, 10'h354, 10'h354, 2'd0, "dvi_ctrl_hsync");
      if (k < 10)      hdmi_both(10'h0AB, 10'h354, 10'h354, 10'h354, 2'd0, "hdmi_ctrl");
      else if (k < 18) hdmi_both(10'h0AB, 10'h0AB, 10'h0AB, 10'h0AB, 2'd1, "hdmi_preamble");
      else             hdmi_both(10'h2CC, 10'h133, 10'h2CC, 10'h133, 2'd2, "hdmi_guard");
    end
    for (int k = 0; k < 3; k++) begin
      drive(32'h0, 1'b1, 1'b0, 1'b1);
      s0 = (k == 1) ? 10'h3FF : 10'h100;
      expect_same(s0, s0, s0, s0, 2'd3, "video_zero");
`ifdef TMDS_DISP_MON_EN
      push(0, -2, due, (k == 0) ? 10'h018 : ((k == 1) ? 10'h002 : 10'h01A), "disp_lane0");
`endif
    end

    // Four-cycle gap with vsync=1.
    for (int k = 0; k < 4; k++) begin
      drive(32'h0, 1'b0, 1'b1, 1'b0);
      expect_all(0, 10'h154, 10'h354, 10'h354, 10'h354, 2'd0, "dvi_gap4");
      if (k < 2) hdmi_both(10'h154, 10'h0AB, 10'h0AB, 10'h0AB, 2'd1, "gap4_preamble");
      else       hdmi_both(10'h2CC, 10'h133, 10'h2CC, 10'h133, 2'd2, "gap4_guard");
    end
    for (int k = 0; k < 2; k++) begin
      drive(32'h0000_00FF, 1'b0, 1'b1, 1'b1);
      s0 = (k == 1) ? 10'h0FF : 10'h200;
      s1 = (k == 1) ? 10'h3FF : 10'h100;
      expect_same(s0, s1, s1, s1, 2'd3, "video_ff");
    end

    // One-cycle gap with both syncs high.
    drive(32'h0, 1'b1, 1'b1, 1'b0);
    expect_all(0, 10'h2AB, 10'h354, 10'h354, 10'h354, 2'd0, "dvi_gap1");
    hdmi_both(10'h2CC, 10'h133, 10'h2CC, 10'h133, 2'd2, "gap1_guard");
    for (int k = 0; k < 2; k++) begin
      drive(32'h0000_0FF0, 1'b1, 1'b1, 1'b1);
      s0 = (k == 1) ? 10'h3FF : 10'h100;
      expect_same((k == 1) ? 10'h0FA : 10'h205, (k == 1) ? 10'h3FA : 10'h105, s0, s0, 2'd3, "video_f0_0f");
    end

    for (int k = 0; k < 24; k++) begin
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      if (k < 12) expect_same(10'h354, 10'h354, 10'h354, 10'h354, 2'd0, "ctrl_idle");
    end
    for (int k = 0; k < 15; k++) begin
      drive(32'h0, 1'b0, 1'b0, 1'b1);
      if (k < 2) begin
        s0 = (k == 1) ? 10'h3FF : 10'h100;
        expect_same(s0, s0, s0, s0, 2'd3, "video_before_reset");
      end
    end

    // Reset pulse while VIDEO symbols are on the outputs.
    #1;
    rst = 1'b1;
    due = cyc;
    for (int k = 0; k < 3; k++) expect_all(k, 10'h000, 10'h000, 10'h000, 10'h000, 2'd0, "async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      due = cyc + k;
      expect_same(10'h354, 10'h354, 10'h354, 10'h354, 2'd0, "restart_ctrl");
    end
    for (int k = 0; k < 3; k++) begin
      drive(32'h0, 1'b0, 1'b0, 1'b1);
      s0 = (k == 1) ? 10'h3FF : 10'h100;
      expect_same(s0, s0, s0, s0, 2'd3, "restart_video");
    end
    for (int k = 0; k < 14; k++) begin
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      if (k < 2) expect_same(10'h354, 10'h354, 10'h354, 10'h354, 2'd0, "tail_ctrl");
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
